// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule controller: expands one cipher key into
// eleven stored round keys and serves registered reads of them.

// SubWord byte: multiplicative inverse in GF(2^8) then the affine map.
module S_box (
  input  logic [7:0] val,
  output logic [7:0] sub
);

  function automatic logic [7:0] gmul(
    input logic [7:0] x,
    input logic [7:0] z
  );
    logic [7:0] p;
    logic [7:0] m;
    p = 8'h00;
    m = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ m;
      m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x4, x8, x16, x32, x64, x128;
  logic [7:0] inv;

  // inverse as val^254 = val^(2+4+...+128); zero maps to zero
  always_comb begin
    x2   = gmul(val, val);
    x4   = gmul(x2, x2);
    x8   = gmul(x4, x4);
    x16  = gmul(x8, x8);
    x32  = gmul(x16, x16);
    x64  = gmul(x32, x32);
    x128 = gmul(x64, x64);
    inv  = gmul(gmul(gmul(x2, x4), gmul(x8, x16)),
                gmul(gmul(x32, x64), x128));
    sub  = inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  end

endmodule

module aes_key_sched_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rd_en,
  input  logic [3:0]   rd_idx,
  output logic         busy,
  output logic         done,
  output logic         ready,
  output logic [127:0] rd_key,
  output logic         rd_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t       state;
  state_t       next_state;
  logic [3:0]   round;
  logic [7:0]   rcon;
  logic [127:0] cur_key;
  logic [127:0] keys [0:10];

  logic         load;
  logic         step;
  logic         last;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot;
  logic [31:0]  subw;
  logic [31:0]  g;
  logic [31:0]  w4, w5, w6, w7;
  logic [127:0] next_key;
  logic [7:0]   rcon_next;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // next state, datapath strobes and status decode
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = EXPAND;
        end
      end
      EXPAND: begin
        busy = 1'b1;
        step = 1'b1;
        if (round == 4'd10) begin
          last       = 1'b1;
          next_state = FINISH;
        end
      end
      FINISH: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // cur_key mirrors slot round-1, so the round function never
  // needs a read port on the storage array
  assign w0 = cur_key[127:96];
  assign w1 = cur_key[95:64];
  assign w2 = cur_key[63:32];
  assign w3 = cur_key[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  S_box u_sb3 (.val(rot[31:24]), .sub(subw[31:24]));
  S_box u_sb2 (.val(rot[23:16]), .sub(subw[23:16]));
  S_box u_sb1 (.val(rot[15:8]),  .sub(subw[15:8]));
  S_box u_sb0 (.val(rot[7:0]),   .sub(subw[7:0]));

  assign g  = subw ^ {rcon, 24'h000000};
  assign w4 = w0 ^ g;
  assign w5 = w4 ^ w1;
  assign w6 = w5 ^ w2;
  assign w7 = w6 ^ w3;
  assign next_key  = {w4, w5, w6, w7};
  assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  // round counter, Rcon, working key and ready flag
  always_ff @(posedge clk) begin
    if (rst) begin
      round   <= 4'd0;
      rcon    <= 8'h01;
      ready   <= 1'b0;
      cur_key <= '0;
    end else if (load) begin
      round   <= 4'd1;
      rcon    <= 8'h01;
      ready   <= 1'b0;
      cur_key <= key_in;
    end else if (step) begin
      round   <= round + 4'd1;
      rcon    <= rcon_next;
      cur_key <= next_key;
      if (last) ready <= 1'b1;
    end
  end

  // round key storage; not reset, ready gates its validity
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load)      keys[0]     <= key_in;
      else if (step) keys[round] <= next_key;
    end
  end

  // registered read port; stale or out-of-range reads return zero
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key   <= '0;
      rd_valid <= 1'b0;
    end else if (rd_en) begin
      if (ready && (rd_idx <= 4'd10)) begin
        rd_key   <= keys[rd_idx];
        rd_valid <= 1'b1;
      end else begin
        rd_key   <= '0;
        rd_valid <= 1'b0;
      end
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, rst input 1.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst  input  1  synchronous active-high reset, sampled on the clk rising edge.
REQ-004 Port start  input  1  request to expand key_in; sampled only in IDLE.
REQ-005 Port key_in  input  128  cipher key; word w0 = [127:96] ... w3 = [31:0].
REQ-006 Port rd_en  input  1  round-key read request.
REQ-007 Port rd_idx  input  4  round-key index, 0..10.
REQ-008 Port busy  output  1  expansion in progress.
REQ-009 Port done  output  1  single-cycle pulse when expansion completes.
REQ-010 Port ready  output  1  all 11 stored round keys are valid.
REQ-011 Port rd_key  output  128  registered read data.
REQ-012 Port rd_valid  output  1  rd_key holds valid data this cycle.

Function
REQ-013 The block SHALL hold a storage array of 11 x 128-bit round keys (index 0..10), a 4-bit round counter and an 8-bit Rcon register.
REQ-014 The FSM SHALL have states IDLE, EXPAND and FINISH.
REQ-015 IDLE with start=1 at edge E0: write key_in to slot 0, set round=1, set Rcon=8'h01, clear ready, set busy, go to EXPAND.
REQ-016 EXPAND at each edge Er (r=1..10): compute round key r from slot r-1 and write it to slot r, then increment round and update Rcon.
REQ-017 Round key r SHALL be computed as follows.
- g = SubWord(RotWord(w3)) XOR {Rcon,24'h0}; RotWord moves byte [31:24] to [7:0].
- w4 = w0^g; w5 = w4^w1; w6 = w5^w2; w7 = w6^w3.
REQ-018 The block SHALL compute SubWord with exactly four instances of the team's existing S_box module, shared across all rounds.
REQ-019 The Rcon update SHALL be xtime: {Rcon[6:0],1'b0} ^ (Rcon[7] ? 8'h1B : 8'h00), giving 01,02,04,08,10,20,40,80,1B,36.
REQ-020 After the write at E10, the FSM SHALL go to FINISH: busy=0, ready=1, done=1 for exactly one cycle, then IDLE.
- done is therefore high in the cycle following the 10th edge after E0.
REQ-021 A start asserted while busy or in FINISH SHALL be ignored and not queued.
REQ-022 A start in IDLE while ready=1 SHALL re-expand: ready drops after E0 and slots are overwritten.
REQ-023 Reads SHALL have 1-cycle latency.
- rd_en=1 at edge E gives rd_key = slot[rd_idx] after E.
- rd_valid = ready & (rd_idx<=10) after E.
REQ-024 When rd_idx>10, or when ready=0 (including during expansion), a read SHALL give rd_key=0 and rd_valid=0.
REQ-025 With rd_en=0, rd_valid SHALL be 0 and rd_key SHALL hold its previous value.
REQ-026 A read in the same cycle as a slot write SHALL return the pre-write content; it is only reachable through the ready gate, so in practice it returns 0/invalid.
REQ-027 Latency from the start edge to the done pulse SHALL be fixed at 10 cycles, independent of the key value.

Reset
REQ-028 When rst=1 at an edge, the block SHALL set state=IDLE, busy=0, done=0, ready=0, rd_valid=0, rd_key=0, round=0 and Rcon=8'h01.
REQ-029 Reset SHALL NOT clear the storage array; ready=0 invalidates it.
REQ-030 rst SHALL take priority over start and rd_en.
REQ-031 Reset during EXPAND SHALL abort expansion; after reset, ready=0 and no done pulse is issued.

Verification
REQ-032 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle -> done pulse 10 cycles later.
- slot1 = a0fafe1788542cb123a339392a6c7605.
- slot10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-033 All-zero key -> slot1 = 62636363626363636263636362636363 and slot10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-034 start pulsed at cycles 3 and 7 after the first accepted start -> exactly one done pulse, and the keys match the first key_in.
REQ-035 rst asserted at round 5, then an immediate new start with the zero key -> ready=0 until a single done pulse, then the zero-key values.
REQ-036 Read sweep with rd_idx 0..15 after ready.
- idx 0..10: correct key, rd_valid=1, one cycle after rd_en.
- idx 11..15: rd_key=0, rd_valid=0.
REQ-037 Read with rd_idx=1 issued during EXPAND -> rd_valid=0 and rd_key=0.
